// File: rtl/dbus_bridge.sv
// Data-bus bridge between the mips32_core data-RAM port and the MCU data slaves.
// Turns the core's single-cycle access into a req/ack transaction, decodes the
// target region, stalls the core until completion and bounds every access with
// a timeout that reports a bus error.
module dbus_bridge #(
  parameter int unsigned TIMEOUT     = 16,            // BUSY cycles before forced completion (2..255)
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF, // read data returned on any error
  parameter logic [3:0]  PERIPH_BASE = 4'h1           // addr[31:28] of the peripheral region
) (
  input  logic        clk,
  input  logic        rst,
  // core side
  input  logic        ram_ce_in,
  input  logic        ram_en_in,
  input  logic [31:0] ram_add_in,
  input  logic [31:0] ram_data_in,
  input  logic [3:0]  ram_sel_in,
  output logic [31:0] ram_data_out,
  output logic        stall_req_out,
  // slave side
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_sel,
  output logic [1:0]  m_region,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  // error reporting
  output logic        bus_err,
  output logic [31:0] err_addr
);

  localparam logic [1:0] REG_RAM      = 2'b00;
  localparam logic [1:0] REG_PERIPH   = 2'b01;
  localparam logic [1:0] REG_UNMAPPED = 2'b10;
  localparam logic [7:0] CNT_LAST     = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [1:0]  w_region;

  // Region decode on the top address nibble of the incoming core address
  always_comb begin
    w_region = REG_UNMAPPED;
    if (ram_add_in[31:28] == PERIPH_BASE) begin
      w_region = REG_PERIPH;
    end else if (ram_add_in[31:28] == 4'h0) begin
      w_region = REG_RAM;
    end
  end

  // Hold the core while a request is seen and the transaction has not reached DONE
  assign stall_req_out = ram_ce_in & (r_state != S_DONE);
  assign ram_data_out  = r_rdata;

  // Transaction FSM: IDLE latches the access, BUSY waits for ack or timeout, DONE releases the core
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_rdata  <= 32'd0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'd0;
      m_wdata  <= 32'd0;
      m_sel    <= 4'd0;
      m_region <= REG_RAM;
      bus_err  <= 1'b0;
      err_addr <= 32'd0;
    end else begin
      bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ram_ce_in) begin
            m_addr   <= ram_add_in;
            m_wdata  <= ram_data_in;
            m_sel    <= ram_sel_in;
            m_region <= w_region;
            if (w_region == REG_UNMAPPED) begin
              // Nothing lives here: complete at once with an error, never touch the bus
              m_req    <= 1'b0;
              m_we     <= 1'b0;
              r_rdata  <= ERR_DATA;
              bus_err  <= 1'b1;
              err_addr <= ram_add_in;
              r_state  <= S_DONE;
            end else begin
              m_req   <= 1'b1;
              m_we    <= ram_en_in;
              r_cnt   <= 8'd0;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (m_ack) begin
            // Ack takes priority over a timeout landing in the same cycle
            r_rdata <= m_we ? 32'd0 : m_rdata;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_rdata  <= ERR_DATA;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            bus_err  <= 1'b1;
            err_addr <= m_addr;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
